// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: host-side controls in, count and
// display/status out.
interface countdown_timer_if;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEG_W = 7;

  logic             load;
  logic [CNT_W-1:0] start_val;
  logic             start;
  logic             pause;
  logic             clear_alarm;
  logic [CNT_W-1:0] count;
  logic [SEG_W-1:0] hex;
  logic             running;
  logic             alarm;

  modport master (
    output load, start_val, start, pause, clear_alarm,
    input  count, hex, running, alarm
  );

  modport slave (
    input  load, start_val, start, pause, clear_alarm,
    output count, hex, running, alarm
  );
endinterface

// File: rtl/countdown_timer.sv
// Prescaled 4-bit down-counter with pause/resume, alarm at zero and an
// active-low 7-segment readout of the remaining count.
module countdown_timer #(
  parameter int unsigned CYCLES_PER_TICK = 50000000
) (
  input logic           clk,
  input logic           reset_n,
  countdown_timer_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned PS_W  = 28;
  localparam logic [PS_W-1:0] TICK_LAST = PS_W'(CYCLES_PER_TICK - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [PS_W-1:0]  presc_q;
  logic             running_q;
  logic             alarm_q;
  logic [SEG_W-1:0] seg_c;
  logic             tick_c;
  logic [CNT_W-1:0] eff_count_c;

  assign tick_c      = (presc_q == TICK_LAST);
  // A same-cycle load decides whether start sees a zero count.
  assign eff_count_c = bus.load ? bus.start_val : count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            count_q <= bus.start_val;
            presc_q <= '0;
          end
          if (bus.start) begin
            if (eff_count_c != CNT_W'(0)) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end else begin
              state_q <= EXPIRED;
              alarm_q <= 1'b1;
            end
          end
        end

        RUN: begin
          if (tick_c) begin
            presc_q <= '0;
            if (count_q != CNT_W'(0)) count_q <= count_q - CNT_W'(1);
            // Reaching zero wins over a coincident pause.
            if (count_q <= CNT_W'(1)) begin
              state_q   <= EXPIRED;
              running_q <= 1'b0;
              alarm_q   <= 1'b1;
            end else if (bus.pause) begin
              state_q   <= PAUSED;
              running_q <= 1'b0;
            end
          end else begin
            presc_q <= presc_q + PS_W'(1);
            if (bus.pause) begin
              state_q   <= PAUSED;
              running_q <= 1'b0;
            end
          end
        end

        PAUSED: begin
          if (bus.load) begin
            count_q <= bus.start_val;
            presc_q <= '0;
            state_q <= IDLE;
          end else if (bus.start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end

        EXPIRED: begin
          count_q <= '0;
          if (bus.clear_alarm) begin
            state_q <= IDLE;
            presc_q <= '0;
            alarm_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= IDLE;
          count_q   <= '0;
          presc_q   <= '0;
          running_q <= 1'b0;
          alarm_q   <= 1'b0;
        end
      endcase
    end
  end

  // Active-low segments {g,f,e,d,c,b,a}.
  always_comb begin
    seg_c = 7'b1111111;
    case (count_q)
      4'h0: seg_c = 7'b1000000;
      4'h1: seg_c = 7'b1111001;
      4'h2: seg_c = 7'b0100100;
      4'h3: seg_c = 7'b0110000;
      4'h4: seg_c = 7'b0011001;
      4'h5: seg_c = 7'b0010010;
      4'h6: seg_c = 7'b0000010;
      4'h7: seg_c = 7'b1111000;
      4'h8: seg_c = 7'b0000000;
      4'h9: seg_c = 7'b0010000;
      4'hA: seg_c = 7'b0001000;
      4'hB: seg_c = 7'b0000011;
      4'hC: seg_c = 7'b1000110;
      4'hD: seg_c = 7'b0100001;
      4'hE: seg_c = 7'b0000110;
      4'hF: seg_c = 7'b0001110;
      default: seg_c = 7'b1111111;
    endcase
  end

  assign bus.count   = count_q;
  assign bus.hex     = seg_c;
  assign bus.running = running_q;
  assign bus.alarm   = alarm_q;
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Seconds-style down-counter: loads a 4-bit start value, decrements once per prescaled tick and raises an alarm at zero.
- Counterpart of the up-counting rate-divider/display-counter path. Used for alarm arming and entry delays.
- Drives one active-low 7-segment digit with the remaining count.
- Contains its own prescaler, so it needs only the board clock.

Parameters:
- CYCLES_PER_TICK, 50000000: clk cycles per decrement. Legal range 1..2^28. The prescaler is 28 bits wide.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- load  in  1  level-sampled; captures start_val when accepted
- start_val  in  4  value to load (0..15)
- start  in  1  begin or resume the countdown
- pause  in  1  freeze the countdown
- clear_alarm  in  1  acknowledge expiry and return to IDLE
- count  out  4  remaining ticks, registered
- hex  out  7  active-low segments {g,f,e,d,c,b,a}, combinational decode of count
- running  out  1  1 while in RUN, registered state decode
- alarm  out  1  1 while in EXPIRED, registered state decode

Behaviour:
- Reset (reset_n=0, asynchronous, immediate):
  - state=IDLE, count=0, prescaler=0.
  - running=0, alarm=0, hex=7'b1000000.
- States: IDLE, RUN, PAUSED, EXPIRED. Transitions happen only on rising clk edges.
- IDLE:
  - load=1: count<=start_val, prescaler<=0.
  - start=1: if the effective count is nonzero, go to RUN; otherwise go to EXPIRED. When load and start are both 1 in the same cycle, the effective count is start_val.
  - pause and clear_alarm are ignored.
- RUN:
  - Each cycle, the prescaler increments. When prescaler==CYCLES_PER_TICK-1: prescaler<=0 and count<=count-1.
  - If that decrement takes count from 1 to 0, go to EXPIRED on the same edge.
  - pause=1: go to PAUSED; the prescaler value is retained.
  - pause on the terminal-tick edge: the decrement still happens; the next state is EXPIRED if count reaches 0, otherwise PAUSED.
  - load, start and clear_alarm are ignored.
- PAUSED:
  - count and prescaler are held.
  - start=1: go to RUN; the prescaler resumes from its held value.
  - load=1: count<=start_val, prescaler<=0, go to IDLE. load has priority over start.
  - pause is ignored.
- EXPIRED:
  - count=0, alarm=1.
  - clear_alarm=1: go to IDLE, prescaler<=0.
  - All other inputs are ignored.
- Timing:
  - First decrement lands on the CYCLES_PER_TICK-th rising edge after the edge that enters RUN.
  - Total run time from start_val N is N*CYCLES_PER_TICK cycles, excluding paused time.
  - alarm rises on the same edge that count becomes 0.
- count never wraps; no decrement occurs from 0.
- hex encoding: standard hex digits 0-F, active-low. Examples:
  - 0 = 1000000
  - 1 = 1111001
  - 8 = 0000000
  - A = 0001000
  - F = 0001110
- CYCLES_PER_TICK=1: decrement on every RUN cycle.

Test Plan:
All scenarios use CYCLES_PER_TICK=4 unless stated otherwise.
- Reset: apply reset_n=0 -> count=0, hex=1000000, running=0, alarm=0. Release reset -> outputs stay at those values with no inputs active.
- Full countdown: load=1 with start_val=3, then start=1 for one cycle -> running=1. count becomes 2, 1, 0 at edges 4, 8 and 12 after the start edge. At edge 12: alarm=1, running=0.
- Pause/resume:
  - Load 5, start. Assert pause at edge 6 -> count=4, and the held prescaler is preserved.
  - Hold for 20 cycles -> count stays 4.
  - start -> count becomes 3 exactly 2 edges later.
- Zero start and acknowledge: load 0, start -> alarm=1 on the next edge. clear_alarm=1 -> IDLE, alarm=0. A second start without load -> EXPIRED again.
- Ignored inputs: load 9 while in RUN -> count is unaffected. start while in EXPIRED -> alarm stays 1. pause coinciding with the final tick -> EXPIRED, not PAUSED.
- Async reset mid-run: drop reset_n between edges while count=2 -> count=0, running=0, hex=1000000 immediately, without waiting for an edge. Also check hex after load F -> 0001110, and after load A -> 0001000.
